// File: rtl/serv_bus_sequencer_pkg.sv
// Shared constants for the serv bus sequencer: FSM state encodings that
// debug/trace logic can decode, and the default watchdog limit.
package serv_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } seq_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/serv_bus_sequencer_if.sv
// Bus bundle for the sequencer: ibus and dbus requester ports, the shared
// Wishbone master port, the error pulse and the FSM state for debug.
//
// Handshake: a requester raises cyc (with address/data stable) and holds it
// until it sees its ack for exactly one cycle; it drops cyc the cycle after
// the ack. On the Wishbone side o_wb_cyc is held until i_wb_ack (or a
// watchdog expiry) ends the transaction. rdt is valid only with its ack.
interface serv_bus_sequencer_if;
  import serv_bus_sequencer_pkg::*;

  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_bus_err;
  seq_state_t  dbg_state;

  // Sequencer side: owns the master port and the requester acks.
  modport master (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr,
           o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_bus_err, dbg_state
  );

  // Environment side: core requesters plus the interconnect slave.
  modport slave (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr,
           o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_bus_err, dbg_state
  );

endinterface

// File: rtl/serv_bus_sequencer_watchdog.sv
// Grant watchdog: counts cycles spent in a grant state and flags the cycle
// on which the count reaches TIMEOUT-1. TIMEOUT=0 removes the counter.
module serv_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  if (TIMEOUT == 0) begin : g_off
    assign o_expire = 1'b0;
  end else begin : g_on
    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Clear while idle so each grant starts from zero; count grant cycles.
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        cnt <= '0;
      end else if (i_en) begin
        cnt <= cnt + W'(1);
      end
    end

    assign o_expire = i_en && (cnt == LAST);
  end

endmodule

// File: rtl/serv_bus_sequencer.sv
// Registered, fair two-requester sequencer sharing one Wishbone master port
// between the ibus and dbus, with a watchdog for unacknowledged transactions.
module serv_bus_sequencer
  import serv_bus_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                  i_clk,
  input logic                  i_rst,
  serv_bus_sequencer_if.master bus
);

  seq_state_t state;
  logic       last_d;
  logic       gnt_i;
  logic       gnt_d;
  logic       req_live;
  logic       expire;
  logic       done;
  logic       timed_out;

  assign gnt_i = (state == ST_GNT_I);
  assign gnt_d = (state == ST_GNT_D);

  // A grant only completes while its requester still holds cyc; a dropped
  // cyc is a protocol violation and ends the grant silently.
  assign req_live  = (gnt_i && bus.i_ibus_cyc) || (gnt_d && bus.i_dbus_cyc);
  assign done      = req_live && (bus.i_wb_ack || expire);
  assign timed_out = req_live && expire && !bus.i_wb_ack;

  serv_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (state == ST_IDLE),
    .i_en     (state != ST_IDLE),
    .o_expire (expire)
  );

  // Arbitration FSM: alternate on contention using last_d, hold one grant
  // per transaction, return to IDLE on ack, expiry or dropped cyc.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      last_d <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_ibus_cyc && (!bus.i_dbus_cyc || last_d)) begin
            state  <= ST_GNT_I;
            last_d <= 1'b0;
          end else if (bus.i_dbus_cyc) begin
            state  <= ST_GNT_D;
            last_d <= 1'b1;
          end
        end
        ST_GNT_I: begin
          if (!bus.i_ibus_cyc || done) state <= ST_IDLE;
        end
        ST_GNT_D: begin
          if (!bus.i_dbus_cyc || done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Master port: ibus address is the idle default; data-side fields are
  // only driven from dbus while it holds the grant.
  assign bus.o_wb_cyc = (state != ST_IDLE);
  assign bus.o_wb_adr = gnt_d ? bus.i_dbus_adr : bus.i_ibus_adr;
  assign bus.o_wb_dat = gnt_d ? bus.i_dbus_dat : 32'h0;
  assign bus.o_wb_sel = gnt_d ? bus.i_dbus_sel : 4'h0;
  assign bus.o_wb_we  = gnt_d && bus.i_dbus_we;

  // Completion: ack goes only to the granted requester; on expiry the read
  // data is forced to zero and the error pulse fires.
  assign bus.o_ibus_ack = gnt_i && done;
  assign bus.o_dbus_ack = gnt_d && done;
  assign bus.o_ibus_rdt = timed_out ? 32'h0 : bus.i_wb_rdt;
  assign bus.o_dbus_rdt = timed_out ? 32'h0 : bus.i_wb_rdt;
  assign bus.o_bus_err  = timed_out;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_serv_bus_sequencer.sv
// Directed bench for serv_bus_sequencer with an 8-cycle watchdog.
module tb_serv_bus_sequencer;
  import serv_bus_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serv_bus_sequencer_if bus ();

  serv_bus_sequencer #(
    .TIMEOUT (8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Clock and global time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_ibus_adr = 32'hABC; bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = 32'h0; bus.i_dbus_dat = 32'h0; bus.i_dbus_sel = 4'h0;
    bus.i_dbus_we = 1'b0; bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt = 32'h0; bus.i_wb_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (bus.o_wb_cyc !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%0h exp=0", bus.o_wb_cyc); end
    checks++; if (bus.o_ibus_ack !== 1'b0 || bus.o_dbus_ack !== 1'b0) begin failures++; $display("FAIL reset_acks got=%0b%0b exp=00", bus.o_ibus_ack, bus.o_dbus_ack); end
    checks++; if (bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", bus.o_bus_err); end
    checks++; if (bus.o_wb_adr !== 32'hABC) begin failures++; $display("FAIL reset_adr got=%08h exp=00000abc", bus.o_wb_adr); end
    checks++; if (bus.o_wb_dat !== 32'h0 || bus.o_wb_sel !== 4'h0 || bus.o_wb_we !== 1'b0) begin failures++; $display("FAIL reset_dat_sel_we got=%08h/%0h/%0h exp=0/0/0", bus.o_wb_dat, bus.o_wb_sel, bus.o_wb_we); end
    checks++; if (bus.dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
  endtask

  task automatic test_ibus_read();
    bus.i_ibus_adr = 32'h100; bus.i_ibus_cyc = 1'b1;
    step();
    checks++; if (bus.o_wb_cyc !== 1'b1) begin failures++; $display("FAIL iread_cyc got=%0h exp=1", bus.o_wb_cyc); end
    checks++; if (bus.o_wb_adr !== 32'h100) begin failures++; $display("FAIL iread_adr got=%08h exp=00000100", bus.o_wb_adr); end
    checks++; if (bus.o_wb_we !== 1'b0) begin failures++; $display("FAIL iread_we got=%0h exp=0", bus.o_wb_we); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.o_ibus_ack !== 1'b0) begin failures++; $display("FAIL iread_early_ack cycle=%0d got=%0h exp=0", k + 1, bus.o_ibus_ack); end
      step();
    end
    bus.i_wb_rdt = 32'hDEADBEEF; bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_ibus_ack !== 1'b1) begin failures++; $display("FAIL iread_ack got=%0h exp=1", bus.o_ibus_ack); end
    checks++; if (bus.o_ibus_rdt !== 32'hDEADBEEF) begin failures++; $display("FAIL iread_rdt got=%08h exp=deadbeef", bus.o_ibus_rdt); end
    checks++; if (bus.o_dbus_ack !== 1'b0) begin failures++; $display("FAIL iread_dbus_ack got=%0h exp=0", bus.o_dbus_ack); end
    step();
    bus.i_wb_ack = 1'b0; bus.i_ibus_cyc = 1'b0;
    #1;
    checks++; if (bus.o_wb_cyc !== 1'b0 || bus.o_ibus_ack !== 1'b0) begin failures++; $display("FAIL iread_idle got=cyc%0h ack%0h exp=cyc0 ack0", bus.o_wb_cyc, bus.o_ibus_ack); end
  endtask

  task automatic test_dbus_write();
    bus.i_dbus_adr = 32'h2000; bus.i_dbus_dat = 32'h12345678;
    bus.i_dbus_sel = 4'b0011; bus.i_dbus_we = 1'b1; bus.i_dbus_cyc = 1'b1;
    step();
    checks++; if (bus.o_wb_cyc !== 1'b1 || bus.o_wb_adr !== 32'h2000) begin failures++; $display("FAIL dwrite_cyc_adr got=%0h/%08h exp=1/00002000", bus.o_wb_cyc, bus.o_wb_adr); end
    checks++; if (bus.o_wb_we !== 1'b1 || bus.o_wb_sel !== 4'b0011) begin failures++; $display("FAIL dwrite_we_sel got=%0h/%0h exp=1/3", bus.o_wb_we, bus.o_wb_sel); end
    checks++; if (bus.o_wb_dat !== 32'h12345678) begin failures++; $display("FAIL dwrite_dat got=%08h exp=12345678", bus.o_wb_dat); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_dbus_ack !== 1'b1 || bus.o_ibus_ack !== 1'b0) begin failures++; $display("FAIL dwrite_ack got=d%0h i%0h exp=d1 i0", bus.o_dbus_ack, bus.o_ibus_ack); end
    step();
    bus.i_wb_ack = 1'b0; bus.i_dbus_cyc = 1'b0; bus.i_dbus_we = 1'b0;
    #1;
    checks++; if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_we !== 1'b0) begin failures++; $display("FAIL dwrite_idle got=cyc%0h we%0h exp=cyc0 we0", bus.o_wb_cyc, bus.o_wb_we); end
  endtask

  task automatic test_back_to_back();
    logic exp_i;
    bus.i_ibus_adr = 32'h300; bus.i_dbus_adr = 32'h400; bus.i_dbus_sel = 4'hF;
    bus.i_ibus_cyc = 1'b1; bus.i_dbus_cyc = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      exp_i = ((t % 2) == 0);
      if (exp_i) bus.i_dbus_cyc = 1'b1; else bus.i_ibus_cyc = 1'b1;
      #1;
      checks++; if (bus.dbg_state !== (exp_i ? ST_GNT_I : ST_GNT_D)) begin failures++; $display("FAIL b2b_grant txn=%0d got=%0d exp=%0d", t, bus.dbg_state, exp_i ? 1 : 2); end
      checks++; if (bus.o_wb_adr !== (exp_i ? 32'h300 : 32'h400)) begin failures++; $display("FAIL b2b_adr txn=%0d got=%08h exp=%08h", t, bus.o_wb_adr, exp_i ? 32'h300 : 32'h400); end
      bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'h55 + t;
      #1;
      checks++; if (bus.o_ibus_ack !== exp_i || bus.o_dbus_ack !== !exp_i) begin failures++; $display("FAIL b2b_ack txn=%0d got=i%0h d%0h exp=i%0h d%0h", t, bus.o_ibus_ack, bus.o_dbus_ack, exp_i, !exp_i); end
      step();
      bus.i_wb_ack = 1'b0;
      if (exp_i) bus.i_ibus_cyc = 1'b0; else bus.i_dbus_cyc = 1'b0;
      if (t == 3) begin bus.i_ibus_cyc = 1'b0; bus.i_dbus_cyc = 1'b0; end
      #1;
      checks++; if (bus.o_wb_cyc !== 1'b0) begin failures++; $display("FAIL b2b_gap txn=%0d got=%0h exp=0", t, bus.o_wb_cyc); end
    end
  endtask

  task automatic test_watchdog();
    bus.i_dbus_adr = 32'h500; bus.i_dbus_we = 1'b0; bus.i_dbus_cyc = 1'b1;
    bus.i_wb_rdt = 32'hFFFFFFFF;
    step();
    for (int g = 1; g < 8; g++) begin
      checks++; if (bus.o_dbus_ack !== 1'b0 || bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL wdog_early cycle=%0d got=ack%0h err%0h exp=ack0 err0", g, bus.o_dbus_ack, bus.o_bus_err); end
      step();
    end
    checks++; if (bus.o_dbus_ack !== 1'b1 || bus.o_bus_err !== 1'b1) begin failures++; $display("FAIL wdog_expire got=ack%0h err%0h exp=ack1 err1", bus.o_dbus_ack, bus.o_bus_err); end
    checks++; if (bus.o_dbus_rdt !== 32'h0) begin failures++; $display("FAIL wdog_rdt got=%08h exp=00000000", bus.o_dbus_rdt); end
    checks++; if (bus.o_ibus_ack !== 1'b0) begin failures++; $display("FAIL wdog_ibus_ack got=%0h exp=0", bus.o_ibus_ack); end
    step();
    bus.i_dbus_cyc = 1'b0;
    #1;
    checks++; if (bus.o_wb_cyc !== 1'b0 || bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL wdog_idle got=cyc%0h err%0h exp=cyc0 err0", bus.o_wb_cyc, bus.o_bus_err); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_ibus_ack !== 1'b0 || bus.o_dbus_ack !== 1'b0) begin failures++; $display("FAIL stray_ack got=i%0h d%0h exp=i0 d0", bus.o_ibus_ack, bus.o_dbus_ack); end
    step();
    checks++; if (bus.o_wb_cyc !== 1'b0) begin failures++; $display("FAIL stray_ack_cyc got=%0h exp=0", bus.o_wb_cyc); end
    bus.i_wb_ack = 1'b0;
  endtask

  task automatic test_ack_on_expiry();
    bus.i_dbus_adr = 32'h510; bus.i_dbus_cyc = 1'b1;
    step();
    for (int g = 1; g < 8; g++) begin
      checks++; if (bus.o_dbus_ack !== 1'b0) begin failures++; $display("FAIL expack_early cycle=%0d got=%0h exp=0", g, bus.o_dbus_ack); end
      step();
    end
    bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'hCAFEF00D;
    #1;
    checks++; if (bus.o_dbus_ack !== 1'b1 || bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL expack_done got=ack%0h err%0h exp=ack1 err0", bus.o_dbus_ack, bus.o_bus_err); end
    checks++; if (bus.o_dbus_rdt !== 32'hCAFEF00D) begin failures++; $display("FAIL expack_rdt got=%08h exp=cafef00d", bus.o_dbus_rdt); end
    step();
    bus.i_wb_ack = 1'b0; bus.i_dbus_cyc = 1'b0;
    #1;
    checks++; if (bus.o_wb_cyc !== 1'b0) begin failures++; $display("FAIL expack_idle got=%0h exp=0", bus.o_wb_cyc); end
  endtask

  task automatic test_cyc_drop();
    bus.i_ibus_adr = 32'h600; bus.i_ibus_cyc = 1'b1;
    step();
    checks++; if (bus.dbg_state !== ST_GNT_I) begin failures++; $display("FAIL drop_grant got=%0d exp=1", bus.dbg_state); end
    bus.i_ibus_cyc = 1'b0;
    #1;
    checks++; if (bus.o_ibus_ack !== 1'b0 || bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL drop_no_ack got=ack%0h err%0h exp=ack0 err0", bus.o_ibus_ack, bus.o_bus_err); end
    step();
    checks++; if (bus.o_wb_cyc !== 1'b0 || bus.o_bus_err !== 1'b0) begin failures++; $display("FAIL drop_idle got=cyc%0h err%0h exp=cyc0 err0", bus.o_wb_cyc, bus.o_bus_err); end
  endtask

  task automatic test_reset_mid_grant();
    bus.i_dbus_adr = 32'h700; bus.i_dbus_cyc = 1'b1;
    step();
    checks++; if (bus.dbg_state !== ST_GNT_D || bus.o_wb_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_grant got=st%0d cyc%0h exp=st2 cyc1", bus.dbg_state, bus.o_wb_cyc); end
    rst = 1'b1; bus.i_ibus_adr = 32'h800; bus.i_ibus_cyc = 1'b1;
    step();
    checks++; if (bus.o_wb_cyc !== 1'b0) begin failures++; $display("FAIL rstmid_cyc got=%0h exp=0", bus.o_wb_cyc); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_ibus_ack !== 1'b0 || bus.o_dbus_ack !== 1'b0) begin failures++; $display("FAIL rstmid_acks got=i%0h d%0h exp=i0 d0", bus.o_ibus_ack, bus.o_dbus_ack); end
    bus.i_wb_ack = 1'b0; rst = 1'b0;
    step();
    checks++; if (bus.dbg_state !== ST_GNT_I || bus.o_wb_adr !== 32'h800) begin failures++; $display("FAIL rstmid_first_contest got=st%0d adr%08h exp=st1 adr00000800", bus.dbg_state, bus.o_wb_adr); end
    bus.i_wb_ack = 1'b1;
    #1;
    checks++; if (bus.o_ibus_ack !== 1'b1) begin failures++; $display("FAIL rstmid_ibus_ack got=%0h exp=1", bus.o_ibus_ack); end
    step();
    bus.i_wb_ack = 1'b0; bus.i_ibus_cyc = 1'b0; bus.i_dbus_cyc = 1'b0;
  endtask

  // Test sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ibus_read();
    test_dbus_write();
    test_back_to_back();
    test_watchdog();
    test_ack_on_expiry();
    test_cyc_drop();
    test_reset_mid_grant();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_bus_sequencer.md
# serv_bus_sequencer

Registered two-requester bus sequencer sharing a single Wishbone master port between the core's instruction bus (ibus) and data bus (dbus). Each requester holds a grant for exactly one transaction. A watchdog terminates transactions the slave never acknowledges. The block sits between the core's ibus/dbus outputs and the SoC interconnect and replaces the combinational ibus/dbus mux when a registered, fair and fault-tolerant master port is required.

## Interface
Parameters:
- TIMEOUT, default 255: cycles a granted transaction may wait for i_wb_ack. 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_ibus_adr  in  32  instruction fetch address.
- i_ibus_cyc  in  1  instruction fetch request.
- o_ibus_rdt  out  32  fetch read data.
- o_ibus_ack  out  1  fetch complete.
- i_dbus_adr  in  32  data address.
- i_dbus_dat  in  32  write data.
- i_dbus_sel  in  4  byte enables.
- i_dbus_we  in  1  write enable.
- i_dbus_cyc  in  1  data request.
- o_dbus_rdt  out  32  data read data.
- o_dbus_ack  out  1  data complete.
- o_wb_adr  out  32  master address.
- o_wb_dat  out  32  master write data.
- o_wb_sel  out  4  master byte enables.
- o_wb_we  out  1  master write enable.
- o_wb_cyc  out  1  master cycle.
- i_wb_rdt  in  32  slave read data.
- i_wb_ack  in  1  slave acknowledge.
- o_bus_err  out  1  one-cycle pulse on watchdog expiry.

## Operation
State machine, 2-bit encoding: IDLE, GNT_I, GNT_D.

IDLE:
- Only i_ibus_cyc high: go to GNT_I.
- Only i_dbus_cyc high: go to GNT_D.
- Both high: grant the requester not granted last, using the last_d flag (reset 1, so ibus wins the first contest).
- Neither high: stay in IDLE.
- last_d updates on every grant.

GNT_I / GNT_D:
- o_wb_cyc=1.
- Address and data muxed from the granted requester.
- o_wb_dat, o_wb_sel and o_wb_we come from dbus in GNT_D. In GNT_I they are 0, with o_wb_we=0.

Termination:
- i_wb_ack in a grant state passes combinationally to the granted requester's ack, then the state goes to IDLE.
- o_ibus_rdt and o_dbus_rdt both carry i_wb_rdt. They are valid only with the matching ack.

Watchdog:
- Counter cleared on entry to a grant state, increments each grant cycle.
- When it reaches TIMEOUT-1 with no ack: assert the granted requester's ack with rdt forced to 0, pulse o_bus_err, go to IDLE.
- An ack in the same cycle as expiry is a normal completion: no o_bus_err, rdt passes through.

Other rules:
- A requester dropping cyc while granted (protocol violation): return to IDLE next cycle, no ack, no error.
- A late i_wb_ack while in IDLE is ignored. No ack is forwarded.
- Non-granted requester acks are always 0.

## Timing
Reset values:
- State IDLE, last_d=1, watchdog 0.
- o_wb_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_bus_err=0.
- o_wb_adr=i_ibus_adr (IDLE default mux); o_wb_dat, o_wb_sel and o_wb_we are 0.

Latency:
- Request sampled in IDLE at edge N; o_wb_cyc is high from cycle N+1.
- Best-case transaction is 2 cycles: grant cycle with same-cycle ack, then IDLE.
- The requester deasserts cyc the cycle after its ack. The IDLE cycle after an ack therefore sees updated requests, so there is no double grant.

Back-to-back and reset:
- Back-to-back requests from both masters alternate strictly.
- Minimum gap between transactions: one IDLE cycle.
- Reset mid-transaction: o_wb_cyc=0 in the cycle after the reset edge. No ack is emitted.

## Structure
- State encodings (IDLE=0, GNT_I=1, GNT_D=2) go in the shared serv constants include, so debug/trace logic can decode them.
- Sub-module serv_bus_watchdog: TIMEOUT parameter.
  - Ports i_clk, i_rst, i_clr, i_en, o_expire.
  - Width $clog2(TIMEOUT+1).
  - With TIMEOUT=0 it ties o_expire low and the counter is optimised away.

## Test plan
- Single ibus read:
  - Stimulus: i_ibus_cyc=1, adr 0x100; slave acks 3 cycles after o_wb_cyc with rdt 0xDEADBEEF.
  - Required: o_wb_adr=0x100; o_ibus_ack for one cycle with o_ibus_rdt=0xDEADBEEF; o_dbus_ack stays 0.
- dbus write:
  - Stimulus: adr 0x2000, dat 0x12345678, sel 4'b0011, we=1; single-cycle ack.
  - Required: o_wb_we=1, o_wb_sel=0011, o_wb_dat=0x12345678; o_dbus_ack in the ack cycle.
- Simultaneous requests:
  - Stimulus: both cyc held high, repeatedly re-requested after each ack.
  - Required: grant order ibus, dbus, ibus, dbus; never two consecutive grants to the same requester.
- Watchdog expiry:
  - Stimulus: TIMEOUT=8, dbus read, slave never acks.
  - Required: o_dbus_ack and o_bus_err pulse on grant cycle 8 with o_dbus_rdt=0; IDLE next; a later stray i_wb_ack produces no ack.
- Ack on expiry cycle:
  - Stimulus: TIMEOUT=8, slave acks exactly on grant cycle 8.
  - Required: normal completion with rdt passed through; o_bus_err=0.
- Reset mid-grant:
  - Stimulus: i_rst asserted during GNT_D.
  - Required: o_wb_cyc=0 next cycle; no acks; the first contest after reset goes to ibus.
